// File: rtl/sega_joy_pkg.sv
// Shared types and constants for the Sega pad scanner.
// SEGA_JOY_6BTN_EN enables the extended 6-button scan.
package sega_joy_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DN    = 1;
  localparam int BTN_LT    = 2;
  localparam int BTN_RT    = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  localparam int LN_UP = 0;
  localparam int LN_DN = 1;
  localparam int LN_LT = 2;
  localparam int LN_RT = 3;
  localparam int LN_B  = 4;
  localparam int LN_C  = 5;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    PAD3 = 2'b01,
    PAD6 = 2'b10
  } sj_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } scan_state_t;

  typedef struct packed {
    logic [11:0] btn;
    sj_type_t    typ;
  } pad_stat_t;

`ifdef SEGA_JOY_6BTN_EN
  localparam logic [2:0] LAST_STEP = 3'd7;
  localparam bit         SIX_EN    = 1'b1;
`else
  localparam logic [2:0] LAST_STEP = 3'd1;
  localparam bit         SIX_EN    = 1'b0;
`endif

endpackage

// File: rtl/sega_pad_decode.sv
// Per-pad line synchroniser, staging, type detection and
// lock-aware commit of the decoded button word.
module sega_pad_decode
  import sega_joy_pkg::*;
(
  input  logic        clk50,
  input  logic        reset,
  input  logic [5:0]  sj,
  input  logic        sample,
  input  logic [2:0]  step,
  input  logic        commit,
  input  logic        lock,
  output logic [11:0] status,
  output logic [1:0]  sj_type,
  output logic        frame_done
);

  logic [5:0]  sync1;
  logic [5:0]  sync2;
  logic [5:0]  p;
  logic [11:0] stg;
  logic        present;
  logic        six;
  logic        pending;
  pad_stat_t   dec;
  pad_stat_t   hold;
  pad_stat_t   cur;

  assign p = ~sync2;

  always_ff @(posedge clk50) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= sj;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      stg     <= '0;
      present <= 1'b0;
      six     <= 1'b0;
    end else if (sample) begin
      unique case (step)
        3'd0: begin
          // A/START land on bits 7:6; a new frame clears the rest
          stg     <= {4'b0, p[LN_C], p[LN_B], 6'b0};
          present <= p[LN_LT] & p[LN_RT];
          six     <= 1'b0;
        end
        3'd1: stg[BTN_C:BTN_UP] <= p;
        3'd4: six <= SIX_EN && (&p[LN_RT:LN_UP]);
        3'd5: begin
          if (six)
            stg[BTN_MODE:BTN_Z] <= p[LN_RT:LN_UP];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dec = '0;
    if (present) begin
      dec.btn = stg;
      dec.typ = PAD3;
      if (six)
        dec.typ = PAD6;
      else
        dec.btn[BTN_MODE:BTN_Z] = '0;
    end
  end

  // hold keeps a finished frame intact while the next scan
  // refills staging under a long lock
  always_ff @(posedge clk50) begin
    if (reset) begin
      cur        <= '0;
      hold       <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (commit && !lock) begin
        cur        <= dec;
        pending    <= 1'b0;
        frame_done <= 1'b1;
      end else if (commit) begin
        hold    <= dec;
        pending <= 1'b1;
      end else if (pending && !lock) begin
        cur        <= hold;
        pending    <= 1'b0;
        frame_done <= 1'b1;
      end
    end
  end

  assign status  = cur.btn;
  assign sj_type = cur.typ;

endmodule

// File: rtl/sega_pad_sequencer.sv
// Frame timer, SEL sequencer and scan FSM for both Sega pads.
// SEGA_JOY_6BTN_EN selects the 8-step scan (default: 2 steps).
module sega_pad_sequencer
  import sega_joy_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int PHASE_US = 8,
  parameter int FRAME_US = 2000
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic [5:0]  sj1,
  input  logic [5:0]  sj2,
  input  logic        lock,
  output logic        sj1_sel,
  output logic        sj2_sel,
  output logic [11:0] status1,
  output logic [11:0] status2,
  output logic [1:0]  sj_type1,
  output logic [1:0]  sj_type2,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW  = $clog2(FRAME_US);
  localparam int SW  = $clog2(PHASE_US);

  logic [PW-1:0] pre_cnt;
  logic [FW-1:0] frm_cnt;
  logic          tick;
  logic          frm_wrap;

  scan_state_t   state;
  scan_state_t   state_nx;
  logic [2:0]    step;
  logic [2:0]    step_nx;
  logic [SW-1:0] ph_cnt;
  logic [SW-1:0] ph_nx;
  logic          sel;
  logic          sel_nx;
  logic          sample;
  logic          commit;
  logic          fd1;
  logic          fd2;

  assign tick     = (pre_cnt == PW'(DIV - 1));
  assign frm_wrap = tick && (frm_cnt == FW'(FRAME_US - 1));

  always_ff @(posedge clk50) begin
    if (reset) begin
      pre_cnt <= '0;
      frm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick)
        frm_cnt <= frm_wrap ? '0 : frm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state  <= ST_IDLE;
      step   <= '0;
      ph_cnt <= '0;
      sel    <= 1'b1;
    end else begin
      state  <= state_nx;
      step   <= step_nx;
      ph_cnt <= ph_nx;
      sel    <= sel_nx;
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    ph_nx    = ph_cnt;
    sample   = 1'b0;
    commit   = 1'b0;
    sel_nx   = 1'b1;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (frm_wrap) begin
          state_nx = ST_SCAN;
          step_nx  = '0;
          ph_nx    = '0;
        end
      end
      (state == ST_SCAN): begin
        if (tick) begin
          if (ph_cnt == SW'(PHASE_US - 1)) begin
            sample = 1'b1;
            ph_nx  = '0;
            if (step == LAST_STEP)
              state_nx = ST_COMMIT;
            else
              step_nx = step + 3'd1;
          end else begin
            ph_nx = ph_cnt + 1'b1;
          end
        end
      end
      (state == ST_COMMIT): begin
        commit   = 1'b1;
        state_nx = ST_IDLE;
        step_nx  = '0;
      end
      default: state_nx = ST_IDLE;
    endcase
    // registered so the pad pins never see decode glitches
    if (state_nx == ST_SCAN)
      sel_nx = step_nx[0];
  end

  assign sj1_sel = sel;
  assign sj2_sel = sel;

  sega_pad_decode u_pad1 (
    .clk50      (clk50),
    .reset      (reset),
    .sj         (sj1),
    .sample     (sample),
    .step       (step),
    .commit     (commit),
    .lock       (lock),
    .status     (status1),
    .sj_type    (sj_type1),
    .frame_done (fd1)
  );

  sega_pad_decode u_pad2 (
    .clk50      (clk50),
    .reset      (reset),
    .sj         (sj2),
    .sample     (sample),
    .step       (step),
    .commit     (commit),
    .lock       (lock),
    .status     (status2),
    .sj_type    (sj_type2),
    .frame_done (fd2)
  );

  assign frame_done = fd1 | fd2;

endmodule

// File: tb/tb_sega_pad_sequencer.sv
// Scoreboard bench for sega_pad_sequencer with behavioural
// 3/6-button pad models on both ports.
`timescale 1ns/1ps
module tb_sega_pad_sequencer;

  localparam int CLK_HZ   = 2_000_000;
  localparam int DIV      = 2;
  localparam int PHASE_US = 4;
  localparam int FRAME_US = 1800;
`ifdef SEGA_JOY_6BTN_EN
  localparam int NSTEP = 8;
  localparam bit SIX   = 1'b1;
`else
  localparam int NSTEP = 2;
  localparam bit SIX   = 1'b0;
`endif
  localparam int FRAME_CLK = FRAME_US * DIV;
  localparam int SCAN_CLK  = NSTEP * PHASE_US * DIV;
  localparam int PULSE_CLK = PHASE_US * DIV;
  localparam int TMO       = 1000;

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        lock  = 1'b0;
  logic [5:0]  sj1;
  logic [5:0]  sj2;
  logic        sj1_sel;
  logic        sj2_sel;
  logic [11:0] status1;
  logic [11:0] status2;
  logic [1:0]  sj_type1;
  logic [1:0]  sj_type2;
  logic        frame_done;

  always #5 clk50 = ~clk50;

  sega_pad_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .PHASE_US (PHASE_US),
    .FRAME_US (FRAME_US)
  ) dut (
    .clk50      (clk50),
    .reset      (reset),
    .sj1        (sj1),
    .sj2        (sj2),
    .lock       (lock),
    .sj1_sel    (sj1_sel),
    .sj2_sel    (sj2_sel),
    .status1    (status1),
    .status2    (status2),
    .sj_type1   (sj_type1),
    .sj_type2   (sj_type2),
    .frame_done (frame_done)
  );

  // pad models: kind 0 unplugged, 1 3-button, 2 6-button
  int          kind1 = 2;
  int          kind2 = 2;
  logic [11:0] btn1 = '0;
  logic [11:0] btn2 = '0;
  int          cnt1 = 0;
  int          cnt2 = 0;
  int          idle1 = TMO;
  int          idle2 = TMO;
  logic        prev1 = 1'b1;
  logic        prev2 = 1'b1;

  always @(posedge clk50) begin
    prev1 <= sj1_sel;
    prev2 <= sj2_sel;
    if (prev1 && !sj1_sel) begin
      cnt1  <= cnt1 + 1;
      idle1 <= 0;
    end else if (idle1 < TMO) idle1 <= idle1 + 1;
    else cnt1 <= 0;
    if (prev2 && !sj2_sel) begin
      cnt2  <= cnt2 + 1;
      idle2 <= 0;
    end else if (idle2 < TMO) idle2 <= idle2 + 1;
    else cnt2 <= 0;
  end

  function automatic logic [5:0] pad_lines(
    input int kind, input logic [11:0] b,
    input logic sel, input int cnt);
    logic [5:0] l;
    l = 6'h3f;
    if (kind != 0) begin
      if (sel) l = ~{b[5], b[4], b[3], b[2], b[1], b[0]};
      else     l = ~{b[7], b[6], 1'b1, 1'b1, b[1], b[0]};
      if (kind == 2 && cnt == 3) begin
        if (sel) l = ~{b[5], b[4], b[11], b[10], b[9], b[8]};
        else     l = ~{b[7], b[6], 4'hf};
      end
      if (kind == 2 && cnt == 4 && !sel)
        l = ~{b[7], b[6], 4'h0};
    end
    return l;
  endfunction

  assign sj1 = pad_lines(kind1, btn1, sj1_sel, cnt1);
  assign sj2 = pad_lines(kind2, btn2, sj2_sel, cnt2);

  // SEL and strobe monitors
  int   sel_falls = 0;
  int   sel_low   = 0;
  int   sel_diff  = 0;
  int   fd_cnt    = 0;
  logic sel_prev  = 1'b1;

  always @(negedge clk50) begin
    sel_prev <= sj1_sel;
    if (sel_prev && !sj1_sel) sel_falls <= sel_falls + 1;
    if (!sj1_sel) sel_low <= sel_low + 1;
    if (sj1_sel !== sj2_sel) sel_diff <= sel_diff + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  typedef struct packed {
    logic [11:0] s1;
    logic [1:0]  t1;
    logic [11:0] s2;
    logic [1:0]  t2;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  function automatic logic [13:0] exp_pad(input int kind,
                                          input logic [11:0] b);
    if (kind == 0) return 14'h0;
    if (kind == 2 && SIX) return {2'b10, b};
    return {2'b01, 4'h0, b[7:0]};
  endfunction

  task automatic push_exp();
    exp_t        e;
    logic [13:0] a;
    logic [13:0] c;
    a = exp_pad(kind1, btn1);
    c = exp_pad(kind2, btn2);
    e.s1 = a[11:0];
    e.t1 = a[13:12];
    e.s2 = c[11:0];
    e.t2 = c[13:12];
    sb.push_back(e);
  endtask

  task automatic check_frame(input string tag, input int bound,
                             output int w);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    w = 0;
    while (!seen && w < bound) begin
      @(negedge clk50);
      w++;
      if (frame_done) seen = 1'b1;
    end
    chk({tag, "_done"}, 32'(seen), 1);
    chk({tag, "_sbq"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_s1"}, status1, e.s1);
      chk({tag, "_t1"}, sj_type1, e.t1);
      chk({tag, "_s2"}, status2, e.s2);
      chk({tag, "_t2"}, sj_type2, e.t2);
    end
  endtask

  task automatic wait_sel(input logic lvl, input string tag);
    int n;
    n = 0;
    while (sj1_sel !== lvl && n < FRAME_CLK + SCAN_CLK) begin
      @(negedge clk50);
      n++;
    end
    chk(tag, sj1_sel, lvl);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel1"}, sj1_sel, 1);
    chk({tag, "_sel2"}, sj2_sel, 1);
    chk({tag, "_s1"}, status1, 0);
    chk({tag, "_s2"}, status2, 0);
    chk({tag, "_t1"}, sj_type1, 0);
    chk({tag, "_t2"}, sj_type2, 0);
  endtask

  localparam int LAT_MAX = FRAME_CLK + SCAN_CLK + 3;
  localparam int BOUND   = FRAME_CLK + SCAN_CLK + 20;

  initial begin
    int w;
    int f0;
    int l0;
    int fd0;
    repeat (4) @(negedge clk50);
    chk_zero("rst");
    chk("rst_fd", frame_done, 0);

    // both pads 6-button, idle
    f0 = sel_falls;
    l0 = sel_low;
    push_exp();
    reset = 1'b0;
    check_frame("idle6", BOUND, w);
    chk("idle6_lat", 32'(w >= FRAME_CLK && w <= LAT_MAX), 1);
    chk("idle6_pulses", sel_falls - f0, NSTEP / 2);
    chk("idle6_lowclk", sel_low - l0, (NSTEP / 2) * PULSE_CLK);
    chk("sel_same", sel_diff, 0);

    // pad 1 3-button with A and RIGHT
    kind1 = 1;
    btn1  = 12'h048;
    push_exp();
    check_frame("p1_3btn", BOUND, w);

    // pad 2 unplugged
    kind2 = 0;
    push_exp();
    check_frame("p2_none", BOUND, w);

    // lock held across COMMIT
    kind1 = 2;
    btn1  = 12'hC00;
    kind2 = 2;
    btn2  = 12'h000;
    push_exp();
    wait_sel(1'b0, "lk_scan");
    lock = 1'b1;
    fd0  = fd_cnt;
    repeat (SCAN_CLK + 110) @(negedge clk50);
    chk("lk_nofd", fd_cnt - fd0, 0);
    chk("lk_hold_s1", status1, 12'h048);
    chk("lk_hold_t1", sj_type1, 1);
    chk("lk_hold_t2", sj_type2, 0);
    fd0  = fd_cnt;
    lock = 1'b0;
    check_frame("lk_rel", 4, w);
    repeat (200) @(negedge clk50);
    chk("lk_one_fd", fd_cnt - fd0, 1);

    // reset in the middle of a scan
    wait_sel(1'b0, "mr_s0");
`ifdef SEGA_JOY_6BTN_EN
    wait_sel(1'b1, "mr_s1");
    wait_sel(1'b0, "mr_s2");
    wait_sel(1'b1, "mr_s3");
`else
    wait_sel(1'b1, "mr_s1");
`endif
    repeat (3) @(negedge clk50);
    reset = 1'b1;
    @(negedge clk50);
    chk_zero("mr");
    kind1 = 1;
    btn1  = 12'h048;
    push_exp();
    reset = 1'b0;
    check_frame("mr_next", BOUND, w);
    chk("mr_lat", 32'(w >= FRAME_CLK && w <= LAT_MAX), 1);

    // 6-button pad 2 with Z held
    kind2 = 2;
    btn2  = 12'h100;
    f0 = sel_falls;
    push_exp();
    check_frame("p2_z", BOUND, w);
    chk("p2_z_pulses", sel_falls - f0, NSTEP / 2);
    chk("sel_same_end", sel_diff, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
